// File: rtl/mult_seq_if.sv
// Handshake and result bundle between the CPU pipeline (master) and the
// sequential multiplier (slave).
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             start;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output a, b, is_signed, start,
        input  hi, lo, busy, done
    );

    modport slave (
        input  a, b, is_signed, start,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_seq.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU (WIDTH x WIDTH -> 2*WIDTH).
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip the RUN phase.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    mult_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] mcand, mcand_d;
    logic [WIDTH-1:0] mplier, mplier_d;
    logic [WIDTH-1:0] hi, hi_d;
    logic [WIDTH-1:0] lo, lo_d;
    logic [CW-1:0]    count, count_d;
    logic             neg, neg_d;
    logic             busy, busy_d;
    logic             done, done_d;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;

    assign bus.hi   = hi;
    assign bus.lo   = lo;
    assign bus.busy = busy;
    assign bus.done = done;

    // NOTE: every register, datapath included, is cleared so an aborted
    // operation can never leak a partial product into hi/lo.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same
            // pre-edge values regardless of statement order.
            state  <= state_d;
            acc    <= acc_d;
            mcand  <= mcand_d;
            mplier <= mplier_d;
            count  <= count_d;
            neg    <= neg_d;
            hi     <= hi_d;
            lo     <= lo_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first keep this block latch-free.
        state_d  = state;
        acc_d    = acc;
        mcand_d  = mcand;
        mplier_d = mplier;
        count_d  = count;
        neg_d    = neg;
        hi_d     = hi;
        lo_d     = lo;
        busy_d   = busy;
        done_d   = 1'b0;
        sum      = '0;
        prod     = {acc, mplier};

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                    if (bus.is_signed) begin
                        mcand_d  = bus.a[WIDTH-1] ? -bus.a : bus.a;
                        mplier_d = bus.b[WIDTH-1] ? -bus.b : bus.b;
                        neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end else begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        neg_d    = 1'b0;
                    end
`ifdef MULT_ZERO_BYPASS_EN
                    if ((bus.a == '0) || (bus.b == '0)) begin
                        mplier_d = '0;
                        neg_d    = 1'b0;
                        state_d  = FIX;
                    end
`endif
                end
            end

            RUN: begin
                sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
                {acc_d, mplier_d} = {sum, mplier[WIDTH-1:1]};
                count_d = count + CW'(1);
                if (count == CW'(WIDTH - 1)) state_d = FIX;
            end

            FIX: begin
                if (neg) prod = -prod;
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end
endmodule
